apb_rr_master: RTL
==================

Name: apb_rr_master

Overview:
- Two-requester APB master that shares one APB slave (4-entry × 4-bit register/memory slave) between two local clients.
- Round-robin arbitration between clients.
- Sequences each granted request through the APB SETUP and ACCESS phases and waits on pready.
- Returns read data and a one-cycle completion pulse to the owning client.

Parameters:
- ADDR_WIDTH, 2, width of paddr and client addresses.
- DATA_WIDTH, 4, width of pwdata/prdata and client data.
- TIMEOUT_CYCLES, 15, maximum ACCESS-phase cycles without pready before abort (used only with the optional feature).

Ports:
- pclk  in  1  clock, all logic on rising edge.
- prst  in  1  synchronous active-low reset.
- req0  in  1  client 0 request; held high until done0.
- wr0  in  1  client 0 direction: 1 = write, 0 = read.
- addr0  in  ADDR_WIDTH  client 0 address.
- wdata0  in  DATA_WIDTH  client 0 write data.
- done0  out  1  client 0 completion pulse.
- rdata0  out  DATA_WIDTH  client 0 read data; valid while done0=1.
- req1, wr1, addr1, wdata1, done1, rdata1: same as client 0, for client 1.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  APB ready from slave.
- prdata  in  DATA_WIDTH  APB read data.
- err  out  1  abort flag; valid with doneN.

Behaviour:
- Reset is synchronous active-low: prst sampled low at a pclk edge sets all of the following.
  - State = IDLE.
  - psel, penable, pwrite = 0; paddr, pwdata = 0.
  - done0, done1, err = 0; rdata0, rdata1 = 0.
  - last_grant = 1, so client 0 wins the first tie.
- Reset mid-transfer abandons the transfer with no done pulse.
- Qualified request: qN = reqN & ~doneN. This masks a request still high in its own done cycle.
- State IDLE:
  - If q0 or q1, pick the grant.
    - If only one is high, that client is granted.
    - If both are high, the client != last_grant is granted.
  - Latch the granted client's wr/addr/wdata into pwrite/paddr/pwdata.
  - psel=1, penable=0; next state SETUP.
  - Otherwise stay in IDLE with psel=0, penable=0.
- State SETUP:
  - Exactly one cycle; psel=1, penable=1; next state ACCESS.
- State ACCESS:
  - psel=1, penable=1; paddr, pwrite, pwdata held stable.
  - pready=1:
    - doneG=1 next cycle.
    - rdataG = prdata captured on this edge for reads; rdataG unchanged for writes.
    - last_grant = G; psel=0, penable=0; next state IDLE.
  - pready=0: stay in ACCESS.
- Timing and latency:
  - Minimum per transfer: request seen in IDLE → done 3 cycles later.
  - The done cycle is an IDLE cycle. Back-to-back requests get a new SETUP in the cycle after done.
  - doneN is exactly one cycle wide; done0 and done1 are never high together.
- paddr/pwdata/pwrite keep their last values in IDLE; only psel qualifies them.
- Client inputs are sampled only in IDLE at grant; changes during a transfer are ignored.

Optional Feature:
- Macro: APB_RR_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready=0: drop psel/penable, go to IDLE, pulse doneG with err=1, set rdataG=0, and update last_grant.
  - pready=1 takes priority on the same cycle.
- Disabled: no counter; ACCESS waits on pready indefinitely; err is tied to 0.

Decomposition:
- Shared package apb_rr_pkg holds the following; client 0 is id 0.
  - State encodings: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2.
  - Default ADDR_WIDTH/DATA_WIDTH.
  - Client id constants.
- Sub-module rr_arb2:
  - Combinational grant from q0, q1, last_grant; outputs gnt_valid and gnt_id.
  - The pointer register stays in the top level.

Test Plan:
- Write sequence: client 0 alone writes addr 0..3, data 4'h3, 4'hA, 4'h5, 4'hF; slave pready=1 in ACCESS → each done0 3 cycles after grant; psel high 2 cycles/transfer; penable low in SETUP, high in ACCESS; slave holds written values.
- Read-back: client 1 reads addr 2 after the writes → rdata1=4'h5 with done1; err=0.
- Contention: req0 and req1 both high from reset, both writes → grant order 0, 1, 0, 1; no client granted twice while the other is pending.
- Wait states: slave holds pready=0 for 4 ACCESS cycles → paddr/pwdata/pwrite stable throughout; done exactly one cycle after pready=1.
- Reset mid-transfer: prst=0 in ACCESS → next edge psel=penable=0, no done; after release, client 0 is granted first.
- Timeout (with APB_RR_TIMEOUT_EN, TIMEOUT_CYCLES=15): pready stuck 0 → abort after 15 ACCESS cycles; done0=1, err=1, rdata0=0; a pending client 1 is granted next.

Source files
------------

// File: rtl/apb_rr_pkg.sv
// apb_rr_pkg: shared state encodings, default widths and client ids for apb_rr_master.
// Revision 1.0
`default_nettype none

package apb_rr_pkg;

  localparam int ADDR_WIDTH_DEF = 2;
  localparam int DATA_WIDTH_DEF = 4;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/apb_rr_master_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant; the last_grant pointer lives in the caller.
// Revision 1.0
`default_nettype none

module rr_arb2
  import apb_rr_pkg::*;
(
  input  logic q0,
  input  logic q1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = q0 | q1;
    gnt_id    = CLIENT0;
    if (q0 && q1) begin
      gnt_id = ~last_grant;
    end else if (q1) begin
      gnt_id = CLIENT1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_rr_master.sv
// apb_rr_master: two-client round-robin APB master (SETUP/ACCESS sequencing, done pulses).
// Optional ACCESS-phase timeout abort: define APB_RR_TIMEOUT_EN. Revision 1.0
`default_nettype none

module apb_rr_master
  import apb_rr_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  done0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  output logic                  err
);

  state_t                state, state_nxt;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt, rdata0_nxt, rdata1_nxt;
  logic                  done0_nxt, done1_nxt, err_nxt;
  logic                  last_grant, last_grant_nxt;
  logic                  owner, owner_nxt;
  logic                  gnt_valid, gnt_id;
  logic                  finish, abort;

`ifdef APB_RR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

  // A request still high during its own done cycle must not win again.
  rr_arb2 u_arb (
    .q0         (req0 & ~done0),
    .q1         (req1 & ~done1),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_nxt      = state;
    psel_nxt       = psel;
    penable_nxt    = penable;
    pwrite_nxt     = pwrite;
    paddr_nxt      = paddr;
    pwdata_nxt     = pwdata;
    rdata0_nxt     = rdata0;
    rdata1_nxt     = rdata1;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    err_nxt        = 1'b0;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    finish         = 1'b0;
    abort          = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
    cnt_nxt        = cnt;
`endif

    case (state)
      IDLE: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        if (gnt_valid) begin
          owner_nxt  = gnt_id;
          pwrite_nxt = (gnt_id == CLIENT1) ? wr1 : wr0;
          paddr_nxt  = (gnt_id == CLIENT1) ? addr1 : addr0;
          pwdata_nxt = (gnt_id == CLIENT1) ? wdata1 : wdata0;
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
`ifdef APB_RR_TIMEOUT_EN
        cnt_nxt     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          finish = 1'b1;
`ifdef APB_RR_TIMEOUT_EN
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (finish || abort) begin
      if (owner == CLIENT1) begin
        done1_nxt = 1'b1;
        if (abort)        rdata1_nxt = '0;
        else if (!pwrite) rdata1_nxt = prdata;
      end else begin
        done0_nxt = 1'b1;
        if (abort)        rdata0_nxt = '0;
        else if (!pwrite) rdata0_nxt = prdata;
      end
      err_nxt        = abort;
      last_grant_nxt = owner;
      psel_nxt       = 1'b0;
      penable_nxt    = 1'b0;
      state_nxt      = IDLE;
    end
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state      <= IDLE;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      last_grant <= CLIENT1;
      owner      <= CLIENT0;
`ifdef APB_RR_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      psel       <= psel_nxt;
      penable    <= penable_nxt;
      pwrite     <= pwrite_nxt;
      paddr      <= paddr_nxt;
      pwdata     <= pwdata_nxt;
      rdata0     <= rdata0_nxt;
      rdata1     <= rdata1_nxt;
      done0      <= done0_nxt;
      done1      <= done1_nxt;
      err        <= err_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
`ifdef APB_RR_TIMEOUT_EN
      cnt        <= cnt_nxt;
`endif
    end
  end

endmodule

`default_nettype wire
